idli_sqi_fetch: RTL

Instruction fetch front end for the idli core. Streams 16-bit instruction words from an external SQI SRAM (23LC1024-style command set) in sequential-read bursts and hands them, with their word address, to the decode stage over a valid/ready handshake. It sits directly upstream of decode, which builds `instr_t` from `o_instr`. Redirects (branches, PC writes) abort the current burst and restart the fetch at a new word address.

---
 rtl/idli_sqi_fetch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/idli_sqi_fetch.sv
// SQI SRAM instruction fetch: first word 15 cycles after reset (redirect + 16), then one word per 4 cycles.
// Stops SCK while 4 nibbles are buffered behind an unaccepted word; `IDLI_SQI_QUAD_ENTER_EN adds a quad-enter preamble.
typedef enum logic {
  SQI_MODE_IN  = 1'b0,
  SQI_MODE_OUT = 1'b1
} sqi_mode_t;

module idli_sqi_fetch (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_addr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_sqi_cs,
  output logic        o_sqi_sck_en,
  output sqi_mode_t   o_sqi_mode,
  output logic [3:0]  o_sqi_data,
  input  logic [3:0]  i_sqi_data
);

  typedef enum logic [2:0] {
    ST_GAP,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ENTER
  } state_t;

`ifdef IDLI_SQI_QUAD_ENTER_EN
  localparam logic [7:0] ENTER_CMD = 8'h38;
`endif

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr;
  logic [15:0] shreg;
  logic [2:0]  nib_cnt;

  logic        full;
  logic        complete;
  logic        can_move;
  logic [15:0] shifted;
  logic [15:0] done_word;
  logic [15:0] word;

  assign full      = (nib_cnt == 3'd4);
  assign shifted   = {shreg[11:0], i_sqi_data};
  assign complete  = full || (o_sqi_sck_en && (nib_cnt == 3'd3));
  assign done_word = full ? shreg : shifted;
  // Bytes arrive low byte first, each high nibble first.
  assign word      = {done_word[7:0], done_word[15:8]};
  assign can_move  = !o_valid || i_ready;

  function automatic logic [3:0] addr_nib(input logic [15:0] a, input logic [2:0] i);
    logic [23:0] ba;
    ba = {7'b0, a, 1'b0};
    case (i)
      3'd0:    addr_nib = ba[23:20];
      3'd1:    addr_nib = ba[19:16];
      3'd2:    addr_nib = ba[15:12];
      3'd3:    addr_nib = ba[11:8];
      3'd4:    addr_nib = ba[7:4];
      3'd5:    addr_nib = ba[3:0];
      default: addr_nib = 4'h0;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
`ifdef IDLI_SQI_QUAD_ENTER_EN
      state        <= ST_ENTER;
      o_sqi_cs     <= 1'b0;
      o_sqi_sck_en <= 1'b1;
      o_sqi_mode   <= SQI_MODE_OUT;
`else
      state        <= ST_GAP;
      o_sqi_cs     <= 1'b1;
      o_sqi_sck_en <= 1'b0;
      o_sqi_mode   <= SQI_MODE_IN;
`endif
      o_sqi_data   <= 4'h0;
      cnt          <= 4'd0;
      addr         <= 16'h0000;
      shreg        <= 16'h0000;
      nib_cnt      <= 3'd0;
      o_valid      <= 1'b0;
      o_instr      <= 16'h0000;
      o_pc         <= 16'h0000;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;

      if (i_redirect
`ifdef IDLI_SQI_QUAD_ENTER_EN
          && (state != ST_ENTER)
`endif
         ) begin
        state        <= ST_GAP;
        cnt          <= 4'd0;
        addr         <= i_redirect_addr;
        shreg        <= 16'h0000;
        nib_cnt      <= 3'd0;
        o_valid      <= 1'b0;
        o_sqi_cs     <= 1'b1;
        o_sqi_sck_en <= 1'b0;
        o_sqi_mode   <= SQI_MODE_IN;
        o_sqi_data   <= 4'h0;
      end else begin
        case (state)
`ifdef IDLI_SQI_QUAD_ENTER_EN
          // The first fetch address is only used after ENTER, so a redirect here just loads it.
          ST_ENTER: begin
            if (i_redirect) addr <= i_redirect_addr;
            if (cnt == 4'd7) begin
              cnt          <= 4'd8;
              o_sqi_cs     <= 1'b1;
              o_sqi_sck_en <= 1'b0;
              o_sqi_mode   <= SQI_MODE_IN;
              o_sqi_data   <= 4'h0;
            end else if (cnt == 4'd8) begin
              state <= ST_GAP;
              cnt   <= 4'd0;
            end else begin
              cnt        <= cnt + 4'd1;
              o_sqi_data <= {3'b000, ENTER_CMD[3'd6 - cnt[2:0]]};
            end
          end
`endif
          ST_GAP: begin
            state        <= ST_CMD;
            cnt          <= 4'd0;
            o_sqi_cs     <= 1'b0;
            o_sqi_sck_en <= 1'b1;
            o_sqi_mode   <= SQI_MODE_OUT;
            o_sqi_data   <= 4'h0;
          end
          ST_CMD: begin
            if (cnt == 4'd0) begin
              cnt        <= 4'd1;
              o_sqi_data <= 4'h3;
            end else begin
              state      <= ST_ADDR;
              cnt        <= 4'd0;
              o_sqi_data <= addr_nib(addr, 3'd0);
            end
          end
          ST_ADDR: begin
            if (cnt == 4'd5) begin
              state      <= ST_DUMMY;
              cnt        <= 4'd0;
              o_sqi_mode <= SQI_MODE_IN;
              o_sqi_data <= 4'h0;
            end else begin
              cnt        <= cnt + 4'd1;
              o_sqi_data <= addr_nib(addr, cnt[2:0] + 3'd1);
            end
          end
          ST_DUMMY: begin
            if (cnt == 4'd0) begin
              cnt <= 4'd1;
            end else begin
              state   <= ST_DATA;
              cnt     <= 4'd0;
              nib_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            if (complete && can_move) begin
              o_valid <= 1'b1;
              o_instr <= word;
              o_pc    <= addr;
              nib_cnt <= 3'd0;
              // Never stream past the top of the 16-bit space; restart cleanly at 0.
              if (addr == 16'hFFFF) begin
                state        <= ST_GAP;
                addr         <= 16'h0000;
                o_sqi_cs     <= 1'b1;
                o_sqi_sck_en <= 1'b0;
              end else begin
                addr         <= addr + 16'd1;
                o_sqi_sck_en <= 1'b1;
              end
            end else if (complete) begin
              shreg        <= done_word;
              nib_cnt      <= 3'd4;
              o_sqi_sck_en <= 1'b0;
            end else begin
              if (o_sqi_sck_en) begin
                shreg   <= shifted;
                nib_cnt <= nib_cnt + 3'd1;
              end
              o_sqi_sck_en <= 1'b1;
            end
          end
          default: begin
            state        <= ST_GAP;
            cnt          <= 4'd0;
            o_sqi_cs     <= 1'b1;
            o_sqi_sck_en <= 1'b0;
            o_sqi_mode   <= SQI_MODE_IN;
            o_sqi_data   <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule
